// File: rtl/ibr128_block_ctrl.sv
// Block controller around the IBR128 stage: packs 32-bit words into 128-bit blocks, runs one block
// at a time and drains the result as words. Define IBR128_TIMEOUT_EN to enable the WAIT watchdog.
module ibr128_block_ctrl #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic         Clk,
    input  logic         RstN,
    input  logic [31:0]  in_data,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         mode_sa,
    input  logic         mode_encrypt,
    output logic         block_start,
    output logic [127:0] pData,
    output logic         sa,
    output logic         encrypt,
    input  logic         block_ready,
    input  logic [127:0] eData,
    output logic [31:0]  out_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         busy,
    output logic         err
);

    typedef enum logic [1:0] {ST_FILL, ST_START, ST_WAIT, ST_DRAIN} state_t;

    state_t       state_q, state_d;
    logic [1:0]   wi_q, wi_d;
    logic [1:0]   wo_q, wo_d;
    logic         rdy_q, rdy_d;
    logic [127:0] pdata_q, pdata_d;
    logic [127:0] obuf_q, obuf_d;
    logic         sa_q, sa_d;
    logic         enc_q, enc_d;

    logic in_fire;
    logic out_fire;
    logic capture;
    logic timeout;

    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;
    // rdy_q tracks block_ready in every state, so a level still high when WAIT begins reads as old
    assign capture  = (state_q == ST_WAIT) && block_ready && !rdy_q;

`ifdef IBR128_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] tmo_q, tmo_d;

    always_ff @(posedge Clk or negedge RstN) begin
        if (!RstN) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_d;
        end
    end

    always_comb begin
        tmo_d = '0;
        if (state_q == ST_WAIT) begin
            tmo_d = tmo_q + TW'(1);
        end
    end

    // A capture landing on the limit cycle takes priority over the timeout
    assign timeout = (state_q == ST_WAIT) && (tmo_q == TW'(TIMEOUT_CYCLES)) && !capture;
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge Clk or negedge RstN) begin
        if (!RstN) begin
            state_q <= ST_FILL;
            wi_q    <= 2'd0;
            wo_q    <= 2'd0;
            rdy_q   <= 1'b0;
            pdata_q <= '0;
            obuf_q  <= '0;
            sa_q    <= 1'b0;
            enc_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wi_q    <= wi_d;
            wo_q    <= wo_d;
            rdy_q   <= rdy_d;
            pdata_q <= pdata_d;
            obuf_q  <= obuf_d;
            sa_q    <= sa_d;
            enc_q   <= enc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_FILL: begin
                if (in_fire && wi_q == 2'd3) begin
                    state_d = ST_START;
                end
            end
            ST_START: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (capture) begin
                    state_d = ST_DRAIN;
                end else if (timeout) begin
                    state_d = ST_FILL;
                end
            end
            ST_DRAIN: begin
                if (out_fire && wo_q == 2'd3) begin
                    state_d = ST_FILL;
                end
            end
            default: begin
                state_d = ST_FILL;
            end
        endcase
    end

    // Word counters wrap naturally, so wi/wo are back at 0 after the fourth transfer
    always_comb begin
        wi_d    = wi_q;
        wo_d    = wo_q;
        pdata_d = pdata_q;
        obuf_d  = obuf_q;
        sa_d    = sa_q;
        enc_d   = enc_q;
        rdy_d   = block_ready;
        if (in_fire) begin
            wi_d = wi_q + 2'd1;
            case (wi_q)
                2'd0: begin
                    pdata_d[127:96] = in_data;
                    sa_d            = mode_sa;
                    enc_d           = mode_encrypt;
                end
                2'd1:    pdata_d[95:64] = in_data;
                2'd2:    pdata_d[63:32] = in_data;
                default: pdata_d[31:0]  = in_data;
            endcase
        end
        if (capture) begin
            obuf_d = eData;
            wo_d   = 2'd0;
        end
        if (out_fire) begin
            wo_d = wo_q + 2'd1;
        end
    end

    always_comb begin
        in_ready    = (state_q == ST_FILL);
        block_start = (state_q == ST_START);
        out_valid   = (state_q == ST_DRAIN);
        busy        = !((state_q == ST_FILL) && (wi_q == 2'd0));
        err         = timeout;
        out_data    = '0;
        if (state_q == ST_DRAIN) begin
            case (wo_q)
                2'd0:    out_data = obuf_q[127:96];
                2'd1:    out_data = obuf_q[95:64];
                2'd2:    out_data = obuf_q[63:32];
                default: out_data = obuf_q[31:0];
            endcase
        end
    end

    assign pData   = pdata_q;
    assign sa      = sa_q;
    assign encrypt = enc_q;

endmodule
